// File: rtl/layer_sequencer_pkg.sv
// Shared stage encodings for the inference pipeline; clock_switch and the
// layer engines decode the same State values.
package layer_sequencer_pkg;

  localparam int STATE_DATAWIDTH = 4;

  typedef enum logic [STATE_DATAWIDTH-1:0] {
    RESET_STATE     = 4'd0,
    IDLE_STATE      = 4'd1,
    CONV1_1_STATE   = 4'd2,
    CONV1_2_STATE   = 4'd3,
    AVG_POOL1_STATE = 4'd4,
    CONV2_1_STATE   = 4'd5,
    CONV2_2_STATE   = 4'd6,
    AVG_POOL2_STATE = 4'd7,
    CONV3_1_STATE   = 4'd8,
    CONV3_2_STATE   = 4'd9,
    AVG_POOL3_STATE = 4'd10,
    FC_STATE        = 4'd11,
    JUDGE_STATE     = 4'd12
  } state_t;

  function automatic logic is_compute(state_t s);
    return (s >= CONV1_1_STATE) && (s <= FC_STATE);
  endfunction

  // Fixed network order; anything outside the compute chain falls back to IDLE.
  function automatic state_t next_layer(state_t s);
    case (s)
      CONV1_1_STATE:   return CONV1_2_STATE;
      CONV1_2_STATE:   return AVG_POOL1_STATE;
      AVG_POOL1_STATE: return CONV2_1_STATE;
      CONV2_1_STATE:   return CONV2_2_STATE;
      CONV2_2_STATE:   return AVG_POOL2_STATE;
      AVG_POOL2_STATE: return CONV3_1_STATE;
      CONV3_1_STATE:   return CONV3_2_STATE;
      CONV3_2_STATE:   return AVG_POOL3_STATE;
      AVG_POOL3_STATE: return FC_STATE;
      FC_STATE:        return JUDGE_STATE;
      default:         return IDLE_STATE;
    endcase
  endfunction

endpackage

// File: rtl/layer_sequencer_watchdog.sv
// Per-layer cycle counter: cleared when a layer is entered, counts while a
// layer runs, and flags the last allowed cycle.
module layer_sequencer_watchdog #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Frame-level controller: walks the layer chain with start/done handshakes,
// judges the FC score and keeps frame statistics.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int                        SCORE_W        = 16,
  parameter logic signed [SCORE_W-1:0] THRESHOLD      = 16'sd0,
  parameter int                        TIMEOUT_CYCLES = 100000,
  parameter int                        CNT_W          = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       layer_done,
  input  logic signed [SCORE_W-1:0]  fc_score,
  output logic [STATE_DATAWIDTH-1:0] State,
  output logic                       layer_start,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       human_detected,
  output logic                       err_timeout,
  output logic [15:0]                frame_cnt
);

  state_t                     state_q, next_state;
  logic                       layer_start_q, busy_q, frame_done_q;
  logic                       human_q, err_timeout_q;
  logic [15:0]                frame_cnt_q;
  logic signed [SCORE_W-1:0]  score_q;
  logic                       done_accept, timeout_hit, enter_compute, wd_expire;

  layer_sequencer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (enter_compute),
    .enable(is_compute(state_q)),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= next_state;
    end
  end

  // done is masked on the layer_start cycle, so a stale pulse cannot skip a layer.
  always_comb begin
    next_state  = state_q;
    done_accept = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      RESET_STATE: next_state = IDLE_STATE;
      IDLE_STATE:  if (start) next_state = CONV1_1_STATE;
      CONV1_1_STATE, CONV1_2_STATE, AVG_POOL1_STATE, CONV2_1_STATE,
      CONV2_2_STATE, AVG_POOL2_STATE, CONV3_1_STATE, CONV3_2_STATE,
      AVG_POOL3_STATE, FC_STATE: begin
        if (layer_done && !layer_start_q) begin
          done_accept = 1'b1;
          next_state  = next_layer(state_q);
        end else if (wd_expire) begin
          timeout_hit = 1'b1;
          next_state  = IDLE_STATE;
        end
      end
      JUDGE_STATE: next_state = IDLE_STATE;
      default:     next_state = IDLE_STATE;
    endcase
    if (abort && (state_q != RESET_STATE)) begin
      next_state  = IDLE_STATE;
      done_accept = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  assign enter_compute = is_compute(next_state) && (next_state != state_q);

  // Result bookkeeping commits on the JUDGE cycle, after frame_done is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      human_q       <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
      score_q       <= '0;
    end else begin
      layer_start_q <= enter_compute;
      busy_q        <= (next_state >= CONV1_1_STATE) && (next_state <= JUDGE_STATE);
      frame_done_q  <= (next_state == JUDGE_STATE);
      if ((state_q == FC_STATE) && done_accept) begin
        score_q <= fc_score;
      end
      if (state_q == JUDGE_STATE) begin
        human_q     <= (score_q > THRESHOLD);
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (timeout_hit) begin
        err_timeout_q <= 1'b1;
      end else if ((state_q == IDLE_STATE) && (next_state == CONV1_1_STATE)) begin
        err_timeout_q <= 1'b0;
      end
    end
  end

  assign State          = state_q;
  assign layer_start    = layer_start_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign human_detected = human_q;
  assign err_timeout    = err_timeout_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
